// File: rtl/frame_writer.sv
// Captures one H_PIXELS x V_LINES RGB444 frame into the frame buffer write port,
// starting on a frame boundary and flagging short, long or truncated frames.
module frame_writer #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_LINES  = 240,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_req,
  input  logic              frame_ack,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic [11:0]       pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_ready,
  output logic              error_flag
);

  localparam int unsigned X_W       = $clog2(H_PIXELS);
  localparam int unsigned Y_W       = $clog2(V_LINES + 1);
  localparam int unsigned FRAME_PIX = H_PIXELS * V_LINES;

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, READY} state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                line_full_q, line_full_d;
  logic                href_q, href_d;
  logic                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                frame_ready_q, frame_ready_d;
  logic                error_flag_q, error_flag_d;
  logic                done;
  logic                trunc;

  // Next-state, counter and write-port logic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    base_d      = base_q;
    line_full_d = line_full_q;
    href_d      = href;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done        = 1'b0;
    trunc       = 1'b0;

    case (state_q)
      IDLE: begin
        x_d         = '0;
        y_d         = '0;
        addr_d      = '0;
        base_d      = '0;
        line_full_d = 1'b0;
        err_d       = 1'b0;
        if (capture_req) state_d = ARM;
      end
      ARM:  if (vsync)  state_d = SYNC;
      SYNC: if (!vsync) state_d = CAPTURE;
      CAPTURE: begin
        if (href && pix_valid) begin
          if (line_full_q) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pix_data;
            addr_d    = addr_q + ADDR_W'(1);
            done      = (addr_q == ADDR_W'(FRAME_PIX - 1));
            if (x_q == X_W'(H_PIXELS - 1)) begin
              x_d         = '0;
              y_d         = y_q + Y_W'(1);
              base_d      = base_q + ADDR_W'(H_PIXELS);
              line_full_d = 1'b1;
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end else if (href_q && !href) begin
          line_full_d = 1'b0;
          // Short line: realign to the start of the next line
          if (x_q != '0) begin
            err_d  = 1'b1;
            x_d    = '0;
            y_d    = y_q + Y_W'(1);
            base_d = base_q + ADDR_W'(H_PIXELS);
            addr_d = base_q + ADDR_W'(H_PIXELS);
            trunc  = (y_q == Y_W'(V_LINES - 1));
          end
        end
        // A final pixel coinciding with vsync still completes the frame cleanly
        if (done) begin
          state_d = READY;
        end else if (vsync || trunc) begin
          state_d = READY;
          err_d   = 1'b1;
        end
      end
      READY: if (frame_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == ARM) || (state_d == SYNC) || (state_d == CAPTURE);
    frame_ready_d = (state_d == READY);
    error_flag_d  = (state_d == READY) && err_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      base_q        <= '0;
      line_full_q   <= 1'b0;
      href_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      error_flag_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      line_full_q   <= line_full_d;
      href_q        <= href_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_ready_q <= frame_ready_d;
      error_flag_q  <= error_flag_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_ready = frame_ready_q;
  assign error_flag  = error_flag_q;

endmodule
